// File: rtl/reservation_station.sv
// Reservation station: buffers issued instructions, snoops the CDB for
// outstanding operands and dispatches the lowest-index ready entry into a
// single output register with valid/ready handshake.

// One station slot: holds op/target/operands and snoops the CDB.
module rs_entry #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  clr_en,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic [OP_WIDTH-1:0]   wr_op,
  input  logic [TAG_WIDTH-1:0]  wr_target,
  input  logic [TAG_WIDTH-1:0]  wr_tag1,
  input  logic [TAG_WIDTH-1:0]  wr_tag2,
  input  logic [DATA_WIDTH-1:0] wr_val1,
  input  logic [DATA_WIDTH-1:0] wr_val2,
  output logic                  valid,
  output logic                  ready,
  output logic [OP_WIDTH-1:0]   op,
  output logic [TAG_WIDTH-1:0]  target,
  output logic [DATA_WIDTH-1:0] val1,
  output logic [DATA_WIDTH-1:0] val2
);
  logic                  valid_q, valid_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [TAG_WIDTH-1:0]  target_q, target_d;
  logic [TAG_WIDTH-1:0]  tag1_q, tag1_d, tag2_q, tag2_d;
  logic [DATA_WIDTH-1:0] val1_q, val1_d, val2_q, val2_d;

  // Next state: snoop, then dispatch clear, then issue write (write wins;
  // the top never writes and clears the same slot in one edge).
  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    target_d = target_q;
    tag1_d   = tag1_q;
    tag2_d   = tag2_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    // A zero tag never matches, so cdb_tag==0 is harmless here.
    if (valid_q && tag1_q != '0 && tag1_q == cdb_tag) begin
      tag1_d = '0;
      val1_d = cdb_data;
    end
    if (valid_q && tag2_q != '0 && tag2_q == cdb_tag) begin
      tag2_d = '0;
      val2_d = cdb_data;
    end
    if (clr_en) valid_d = 1'b0;
    if (wr_en) begin
      valid_d  = 1'b1;
      op_d     = wr_op;
      target_d = wr_target;
      tag1_d   = wr_tag1;
      tag2_d   = wr_tag2;
      val1_d   = wr_val1;
      val2_d   = wr_val2;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      op_q     <= '0;
      target_q <= '0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      val1_q   <= '0;
      val2_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      op_q     <= op_d;
      target_q <= target_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag2_d;
      val1_q   <= val1_d;
      val2_q   <= val2_d;
    end
  end

  assign valid  = valid_q;
  assign ready  = valid_q && (tag1_q == '0) && (tag2_q == '0);
  assign op     = op_q;
  assign target = target_q;
  assign val1   = val1_q;
  assign val2   = val2_q;
endmodule

module reservation_station #(
  parameter int UNIT_ID    = 0,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int OP_WIDTH   = 6,
  parameter int UNIT_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [UNIT_WIDTH-1:0]        in_ex_unit,
  input  logic [OP_WIDTH-1:0]          in_op,
  input  logic [TAG_WIDTH-1:0]         in_tag1,
  input  logic [TAG_WIDTH-1:0]         in_tag2,
  input  logic [DATA_WIDTH-1:0]        in_val1,
  input  logic [DATA_WIDTH-1:0]        in_val2,
  input  logic [TAG_WIDTH-1:0]         in_target,
  input  logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic [DATA_WIDTH-1:0]        cdb_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ex_valid,
  input  logic                         ex_ready,
  output logic [OP_WIDTH-1:0]          ex_op,
  output logic [DATA_WIDTH-1:0]        ex_val1,
  output logic [DATA_WIDTH-1:0]        ex_val2,
  output logic [TAG_WIDTH-1:0]         ex_target
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]                 ent_valid, ent_ready;
  logic [DEPTH-1:0][OP_WIDTH-1:0]   ent_op;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]  ent_target;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_val1, ent_val2;

  logic                  issue_ok, load, disp_hit, free_hit;
  logic [IW-1:0]         disp_idx, free_idx;
  logic [TAG_WIDTH-1:0]  wr_tag1, wr_tag2;
  logic [DATA_WIDTH-1:0] wr_val1, wr_val2;
  logic [CW-1:0]         count_c;

  logic                  ex_valid_q, ex_valid_d;
  logic [OP_WIDTH-1:0]   ex_op_q, ex_op_d;
  logic [DATA_WIDTH-1:0] ex_val1_q, ex_val1_d, ex_val2_q, ex_val2_d;
  logic [TAG_WIDTH-1:0]  ex_target_q, ex_target_d;

  // Occupancy from registered valid bits only; no input feeds full/count.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < DEPTH; i++) count_c = count_c + CW'(ent_valid[i]);
  end
  assign count = count_c;
  assign full  = &ent_valid;

  // Lowest-index ready and lowest-index free slot (scan high to low so the
  // lowest match is the last write).
  always_comb begin
    disp_hit = 1'b0;
    disp_idx = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent_ready[i]) begin
        disp_hit = 1'b1;
        disp_idx = IW'(i);
      end
      if (!ent_valid[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Issue filter and same-cycle CDB forwarding for the incoming operands.
  always_comb begin
    issue_ok = (in_target != '0) && (in_ex_unit == UNIT_WIDTH'(UNIT_ID)) &&
               !full && free_hit;
    wr_tag1  = in_tag1;
    wr_val1  = in_val1;
    wr_tag2  = in_tag2;
    wr_val2  = in_val2;
    if (in_tag1 != '0 && in_tag1 == cdb_tag) begin
      wr_tag1 = '0;
      wr_val1 = cdb_data;
    end
    if (in_tag2 != '0 && in_tag2 == cdb_tag) begin
      wr_tag2 = '0;
      wr_val2 = cdb_data;
    end
  end

  assign load = !ex_valid_q || ex_ready;

  // Issue targets a slot that is free before the edge, so it can never be
  // the slot being dispatched in the same edge.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .OP_WIDTH  (OP_WIDTH)
    ) u_ent (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (issue_ok && (free_idx == IW'(g))),
      .clr_en   (load && disp_hit && (disp_idx == IW'(g))),
      .cdb_tag  (cdb_tag),
      .cdb_data (cdb_data),
      .wr_op    (in_op),
      .wr_target(in_target),
      .wr_tag1  (wr_tag1),
      .wr_tag2  (wr_tag2),
      .wr_val1  (wr_val1),
      .wr_val2  (wr_val2),
      .valid    (ent_valid[g]),
      .ready    (ent_ready[g]),
      .op       (ent_op[g]),
      .target   (ent_target[g]),
      .val1     (ent_val1[g]),
      .val2     (ent_val2[g])
    );
  end

  // Dispatch register: reload when empty or consumed; hold under backpressure.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_val1_d   = ex_val1_q;
    ex_val2_d   = ex_val2_q;
    ex_target_d = ex_target_q;
    if (load) begin
      ex_valid_d = disp_hit;
      if (disp_hit) begin
        ex_op_d     = ent_op[disp_idx];
        ex_val1_d   = ent_val1[disp_idx];
        ex_val2_d   = ent_val2[disp_idx];
        ex_target_d = ent_target[disp_idx];
      end
    end
  end

  // Dispatch register flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_val1_q   <= '0;
      ex_val2_q   <= '0;
      ex_target_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_val1_q   <= ex_val1_d;
      ex_val2_q   <= ex_val2_d;
      ex_target_q <= ex_target_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op     = ex_op_q;
  assign ex_val1   = ex_val1_q;
  assign ex_val2   = ex_val2_q;
  assign ex_target = ex_target_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the station.
module tb_reservation_station;
  localparam int DEPTH = 4;
  localparam int UID   = 2;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int OW    = 6;
  localparam int UW    = 3;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [UW-1:0] in_ex_unit;
  logic [OW-1:0] in_op;
  logic [TW-1:0] in_tag1, in_tag2, in_target, cdb_tag;
  logic [DW-1:0] in_val1, in_val2, cdb_data;
  logic          full, ex_valid, ex_ready;
  logic [CW-1:0] count;
  logic [OW-1:0] ex_op;
  logic [DW-1:0] ex_val1, ex_val2;
  logic [TW-1:0] ex_target;

  int checks = 0;
  int failures = 0;

  reservation_station #(
    .UNIT_ID(UID), .DEPTH(DEPTH), .DATA_WIDTH(DW),
    .TAG_WIDTH(TW), .OP_WIDTH(OW), .UNIT_WIDTH(UW)
  ) dut (
    .clk(clk), .rst(rst), .in_ex_unit(in_ex_unit), .in_op(in_op),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .in_val1(in_val1), .in_val2(in_val2),
    .in_target(in_target), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .full(full), .count(count), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_target(ex_target)
  );

  always #5 clk = ~clk;

  // Reference model: a list of waiting instructions plus one output slot.
  typedef struct {
    bit            v;
    logic [OW-1:0] op;
    logic [TW-1:0] tg, t1, t2;
    logic [DW-1:0] x1, x2;
  } ent_t;

  ent_t          m_ent[DEPTH];
  bit            m_exv;
  logic [OW-1:0] m_exop;
  logic [TW-1:0] m_ext;
  logic [DW-1:0] m_ex1, m_ex2;

  // Advance one clock: apply the station rules to the model using the
  // inputs held across this edge, then move the model to the new state.
  task automatic tick();
    ent_t          nx[DEPTH];
    bit            nexv;
    logic [OW-1:0] nop;
    logic [TW-1:0] nt;
    logic [DW-1:0] n1, n2;
    int            used, pick, slot;
    bit            acc;
    nx = m_ent; nexv = m_exv; nop = m_exop; nt = m_ext; n1 = m_ex1; n2 = m_ex2;
    if (rst) begin
      foreach (nx[i]) nx[i] = '{0, '0, '0, '0, '0, '0, '0};
      nexv = 0; nop = '0; nt = '0; n1 = '0; n2 = '0;
    end else begin
      used = 0; pick = -1; slot = -1;
      foreach (m_ent[i]) begin
        if (m_ent[i].v) used++;
        if (pick < 0 && m_ent[i].v && m_ent[i].t1 == 0 && m_ent[i].t2 == 0) pick = i;
        if (slot < 0 && !m_ent[i].v) slot = i;
      end
      acc = (in_target != 0) && (in_ex_unit == UID) && (used < DEPTH);
      if (!m_exv || ex_ready) begin
        nexv = (pick >= 0);
        if (pick >= 0) begin
          nop = m_ent[pick].op; nt = m_ent[pick].tg;
          n1 = m_ent[pick].x1;  n2 = m_ent[pick].x2;
          nx[pick].v = 0;
        end
      end
      foreach (m_ent[i]) if (m_ent[i].v) begin
        if (m_ent[i].t1 != 0 && m_ent[i].t1 == cdb_tag) begin nx[i].t1 = 0; nx[i].x1 = cdb_data; end
        if (m_ent[i].t2 != 0 && m_ent[i].t2 == cdb_tag) begin nx[i].t2 = 0; nx[i].x2 = cdb_data; end
      end
      if (acc) begin
        nx[slot] = '{1, in_op, in_target, in_tag1, in_tag2, in_val1, in_val2};
        if (in_tag1 != 0 && in_tag1 == cdb_tag) begin nx[slot].t1 = 0; nx[slot].x1 = cdb_data; end
        if (in_tag2 != 0 && in_tag2 == cdb_tag) begin nx[slot].t2 = 0; nx[slot].x2 = cdb_data; end
      end
    end
    @(posedge clk);
    #1;
    m_ent = nx; m_exv = nexv; m_exop = nop; m_ext = nt; m_ex1 = n1; m_ex2 = n2;
  endtask

  task automatic clear_in();
    in_ex_unit = UW'(UID); in_op = '0; in_tag1 = '0; in_tag2 = '0;
    in_val1 = '0; in_val2 = '0; in_target = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_issue(input logic [TW-1:0] tg, input logic [TW-1:0] t1,
                           input logic [TW-1:0] t2, input logic [DW-1:0] v1,
                           input logic [DW-1:0] v2);
    in_ex_unit = UW'(UID); in_op = OW'(tg + 1); in_target = tg;
    in_tag1 = t1; in_tag2 = t2; in_val1 = v1; in_val2 = v2;
  endtask

  task automatic do_reset();
    clear_in(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    ex_ready = 1'b1;
    do_reset();
    checks++; if (count !== 0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0)    begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    checks++; if (ex_target !== 0 || ex_op !== 0 || ex_val1 !== 0 || ex_val2 !== 0)
      begin failures++; $display("FAIL reset_ex_data got=%0h/%0h/%0h/%0h exp=0", ex_target, ex_op, ex_val1, ex_val2); end
  endtask

  task automatic test_ready_issue();
    do_reset(); ex_ready = 1'b1;
    set_issue(5, 0, 0, 32'h11, 32'h22); tick(); clear_in();
    checks++; if (count !== 1 || ex_valid !== 1'b0)
      begin failures++; $display("FAIL ready_edge1 got count=%0d exv=%b exp 1/0", count, ex_valid); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_target !== 5 || ex_val1 !== 32'h11 || ex_val2 !== 32'h22)
      begin failures++; $display("FAIL ready_dispatch got v=%b t=%0d %0h %0h exp 1 5 11 22", ex_valid, ex_target, ex_val1, ex_val2); end
    checks++; if (count !== 0) begin failures++; $display("FAIL ready_count got=%0d exp=0", count); end
  endtask

  task automatic test_wait_operand();
    do_reset(); ex_ready = 1'b1;
    set_issue(3, 7, 0, 32'h0, 32'h5); tick(); clear_in();
    tick(); tick();
    checks++; if (count !== 1 || ex_valid !== 1'b0)
      begin failures++; $display("FAIL wait_pending got count=%0d exv=%b exp 1/0", count, ex_valid); end
    cdb_tag = 7; cdb_data = 32'hABCD; tick(); clear_in();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL wait_snoop_edge got exv=%b exp=0", ex_valid); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_val1 !== 32'hABCD || ex_val2 !== 32'h5 || ex_target !== 3)
      begin failures++; $display("FAIL wait_dispatch got v=%b %0h %0h t=%0d exp 1 abcd 5 3", ex_valid, ex_val1, ex_val2, ex_target); end
  endtask

  task automatic test_forward();
    do_reset(); ex_ready = 1'b1;
    set_issue(9, 0, 6, 32'h1, 32'h0); cdb_tag = 6; cdb_data = 32'h99; tick(); clear_in();
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_val2 !== 32'h99 || ex_val1 !== 32'h1 || ex_target !== 9)
      begin failures++; $display("FAIL forward got v=%b %0h %0h t=%0d exp 1 1 99 9", ex_valid, ex_val1, ex_val2, ex_target); end
  endtask

  task automatic test_fill();
    do_reset(); ex_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_issue(TW'(i + 1), TW'(8 + i), 0, 32'h0, 32'h0); tick();
    end
    clear_in();
    checks++; if (full !== 1'b1 || count !== DEPTH)
      begin failures++; $display("FAIL fill_full got full=%b count=%0d exp 1/%0d", full, count, DEPTH); end
    set_issue(12, 0, 0, 32'h3, 32'h4); tick(); clear_in();
    checks++; if (count !== DEPTH || ex_valid !== 1'b0)
      begin failures++; $display("FAIL fill_reject got count=%0d exv=%b exp %0d/0", count, ex_valid, DEPTH); end
    cdb_tag = 8; cdb_data = 32'h77; tick(); clear_in();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_snoop_full got=%b exp=1", full); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_target !== 1 || ex_val1 !== 32'h77 || full !== 1'b0 || count !== DEPTH-1)
      begin failures++; $display("FAIL fill_drain got v=%b t=%0d %0h full=%b cnt=%0d", ex_valid, ex_target, ex_val1, full, count); end
  endtask

  task automatic test_backpressure();
    do_reset(); ex_ready = 1'b0;
    set_issue(1, 0, 0, 32'hA1, 32'hB1); tick();
    set_issue(2, 0, 0, 32'hA2, 32'hB2); tick(); clear_in();
    for (int i = 0; i < 5; i++) begin
      checks++; if (ex_valid !== 1'b1 || ex_target !== 1 || ex_val1 !== 32'hA1 || ex_val2 !== 32'hB1 || count !== 1)
        begin failures++; $display("FAIL bp_hold[%0d] got v=%b t=%0d %0h cnt=%0d exp 1 1 a1 1", i, ex_valid, ex_target, ex_val1, count); end
      tick();
    end
    ex_ready = 1'b1; tick();
    checks++; if (ex_valid !== 1'b1 || ex_target !== 2 || ex_val1 !== 32'hA2 || ex_val2 !== 32'hB2)
      begin failures++; $display("FAIL bp_release got v=%b t=%0d %0h exp 1 2 a2", ex_valid, ex_target, ex_val1); end
  endtask

  task automatic test_mid_reset();
    do_reset(); ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(TW'(i + 1), 0, 0, 32'(i), 32'(i)); tick();
    end
    checks++; if (count !== 3 || ex_valid !== 1'b1)
      begin failures++; $display("FAIL mid_pre got count=%0d exv=%b exp 3/1", count, ex_valid); end
    set_issue(7, 0, 0, 32'h5, 32'h5); cdb_tag = 3; rst = 1'b1; tick(); rst = 1'b0; clear_in();
    checks++; if (count !== 0 || full !== 1'b0 || ex_valid !== 1'b0 || ex_target !== 0)
      begin failures++; $display("FAIL mid_reset got cnt=%0d full=%b exv=%b t=%0d exp 0", count, full, ex_valid, ex_target); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      in_ex_unit = ($urandom_range(0, 3) == 0) ? UW'($urandom) : UW'(UID);
      in_op      = OW'($urandom);
      in_target  = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom);
      in_tag1    = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom);
      in_tag2    = ($urandom_range(0, 1) == 0) ? '0 : TW'($urandom);
      in_val1    = $urandom;
      in_val2    = $urandom;
      cdb_tag    = TW'($urandom);
      cdb_data   = $urandom;
      ex_ready   = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (count !== CW'(m_ent[0].v + m_ent[1].v + m_ent[2].v + m_ent[3].v) ||
          full !== (m_ent[0].v & m_ent[1].v & m_ent[2].v & m_ent[3].v) ||
          ex_valid !== m_exv ||
          (m_exv && (ex_op !== m_exop || ex_target !== m_ext || ex_val1 !== m_ex1 || ex_val2 !== m_ex2))) begin
        failures++;
        if (bad < 10) $display("FAIL rand[%0d] got cnt=%0d full=%b v=%b op=%0h t=%0d %0h %0h exp v=%b op=%0h t=%0d %0h %0h",
                               c, count, full, ex_valid, ex_op, ex_target, ex_val1, ex_val2, m_exv, m_exop, m_ext, m_ex1, m_ex2);
        bad++;
      end
    end
    rst = 1'b0; clear_in();
  endtask

  initial begin
    rst = 1'b1; ex_ready = 1'b1; clear_in();
    foreach (m_ent[i]) m_ent[i] = '{0, '0, '0, '0, '0, '0, '0};
    m_exv = 0; m_exop = '0; m_ext = '0; m_ex1 = '0; m_ex2 = '0;
    test_reset();
    test_ready_issue();
    test_wait_operand();
    test_forward();
    test_fill();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- UNIT_ID, 0, execution-unit index this station serves.
- DEPTH, 4, number of entries (power of two, 2..16).
- DATA_WIDTH, 32, operand width.
- TAG_WIDTH, 4, instruction tag width; tag 0 = "no producer / value valid".
- OP_WIDTH, 6, opcode width.
- UNIT_WIDTH, 3, ex_unit selector width.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset.
- in_ex_unit, in, UNIT_WIDTH, target unit of the issued instruction.
- in_op, in, OP_WIDTH, opcode.
- in_tag1, in_tag2, in, TAG_WIDTH, producer tags of operands 1/2.
- in_val1, in_val2, in, DATA_WIDTH, operand values (meaningful only when tag==0).
- in_target, in, TAG_WIDTH, ROB tag of the instruction; 0 = no issue this cycle.
- cdb_tag, in, TAG_WIDTH, write-back broadcast tag; 0 = no broadcast.
- cdb_data, in, DATA_WIDTH, write-back broadcast value.
- full, out, 1, every entry occupied.
- count, out, clog2(DEPTH+1), number of occupied entries.
- ex_valid, out, 1, dispatch output holds an instruction.
- ex_ready, in, 1, execution unit accepts the dispatch output.
- ex_op, out, OP_WIDTH, dispatched opcode.
- ex_val1, ex_val2, out, DATA_WIDTH, dispatched operands.
- ex_target, out, TAG_WIDTH, dispatched ROB tag.
REQ-003 One clock, clk; reset rst is synchronous and active-high; all state updates on the rising edge of clk.

Function
REQ-004 Issue accepted iff in_target!=0, in_ex_unit==UNIT_ID and full==0; otherwise inputs are ignored.
REQ-005 Accepted issue writes the lowest-index free entry: valid=1, op, target, tag1/2, val1/2.
REQ-006 Issue-time forwarding: if in_tagN!=0 and in_tagN==cdb_tag in the same cycle, the entry stores tagN=0 and valN=cdb_data.
REQ-007 Snoop: each cycle, for every valid entry and N in {1,2}, if tagN!=0 and tagN==cdb_tag, set tagN=0 and valN=cdb_data; cdb_tag==0 never matches.
REQ-008 An entry is ready when valid and tag1==0 and tag2==0, evaluated on registered state only; tags cleared by a broadcast make the entry ready in the following cycle.
REQ-009 Output register load condition: (ex_valid==0) or (ex_ready==1).
REQ-010 When the load condition holds and any entry is ready, the lowest-index ready entry is copied to ex_op/ex_val1/ex_val2/ex_target, ex_valid=1 and that entry is freed in the same edge.
REQ-011 When the load condition holds and no entry is ready, ex_valid=0 next cycle; ex_* data may hold stale values.
REQ-012 While ex_valid==1 and ex_ready==0, all ex_* outputs remain stable.
REQ-013 An entry written at edge N is dispatchable no earlier than the cycle after edge N; minimum issue-to-ex_valid latency is 2 edges.
REQ-014 full and count are derived combinationally from the entry valid bits only (no path from any input).
REQ-015 Slot freed by dispatch at edge N is reusable by an issue at edge N+1; when full==1, an issue is rejected even if a dispatch frees a slot in the same cycle.
REQ-016 Issue, snoop and dispatch in the same cycle are all applied; a freed entry is never snooped or written twice in that edge.
REQ-017 count never exceeds DEPTH; no other overflow or underflow is possible.

Reset
REQ-018 rst=1 at an edge: all entries invalid, ex_valid=0, ex_op/ex_val1/ex_val2/ex_target=0, hence full=0 and count=0.
REQ-019 rst overrides issue, snoop and dispatch in the same cycle; in-flight entries and the output register are discarded.

Verification
REQ-020 Ready issue: target=5, tags 0, vals 0x11/0x22, ex_ready=1 -> ex_valid=1 two edges later with ex_target=5, ex_val1=0x11, ex_val2=0x22; count returns to 0.
REQ-021 Waiting operand: issue target=3, tag1=7; CDB tag=7, data=0xABCD three cycles later -> ex_valid rises the edge after the next, ex_val1=0xABCD.
REQ-022 Forward on issue: in_tag2=6 with cdb_tag=6, cdb_data=0x99 in the same cycle -> dispatch with ex_val2=0x99 at minimum latency.
REQ-023 Fill: DEPTH issues with unresolved tags -> full=1, count=DEPTH; a further issue is ignored; one broadcast frees one entry after dispatch and full falls.
REQ-024 Backpressure: ex_ready=0 with two ready entries -> ex_* stable at entry 0 for 5 cycles; ex_ready=1 -> entry 1 appears on the next edge.
REQ-025 Mid-operation reset: 3 entries valid, ex_valid=1, rst pulse -> next cycle count=0, full=0, ex_valid=0, ex_target=0.
